// File: rtl/sa_ctrl_pkg.sv
// Shared systolic-array control types: FSM states, layer config record and
// the config legality check used by both the read and write sequencers.
package sa_ctrl_pkg;

    localparam int CH_DW_MAX = 8;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } fsm_state_t;

    typedef struct packed {
        logic [1:0]           stride;
        logic [3:0]           kernel_dim;
        logic [5:0]           infmap_rows;
        logic [CH_DW_MAX-1:0] num_ch;
    } cfg_t;

    // A pass is meaningful only with a nonzero stride, kernel and channel
    // count, and a kernel that fits inside the feature map.
    function automatic logic cfg_legal(input cfg_t cfg);
        return (cfg.stride != 2'd0) &&
               (cfg.kernel_dim != 4'd0) &&
               ({2'b00, cfg.kernel_dim} <= cfg.infmap_rows) &&
               (cfg.num_ch != '0);
    endfunction

endpackage

// File: rtl/wrap_cnt.sv
// Generic stepping up-counter; wraps to zero when the next value would pass
// the limit, and reports the wrap so counters can be chained as carries.
module wrap_cnt #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         inc,
    input  logic [W:0]   step,
    input  logic [W:0]   limit,
    output logic [W-1:0] count,
    output logic         wrap
);

    logic [W:0] next_val;

    // One extra bit on the sum keeps the limit compare free of overflow.
    assign next_val = {1'b0, count} + step;
    assign wrap     = inc && (next_val > limit);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc) begin
            count <= wrap ? '0 : next_val[W-1:0];
        end
    end

endmodule

// File: rtl/ofmap_rd_sched.sv
// Read-address sequencer for ram_out: walks the stored feature map in
// sliding-window order (ry, bx, c, ky, kx), throttled by the array's ready.
module ofmap_rd_sched #(
    parameter int ADDR_DW = 5,
    parameter int CH_DW   = 4,
    parameter int ROWS    = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [1:0]         cfg_stride,
    input  logic [3:0]         cfg_kernel_dim,
    input  logic [5:0]         cfg_infmap_rows,
    input  logic [CH_DW-1:0]   cfg_num_ch,
    input  logic               ready,
    output logic               RAenable,
    output logic [CH_DW-1:0]   ch_select_r,
    output logic [ADDR_DW-1:0] ram_select_r_x,
    output logic [ADDR_DW-1:0] ram_select_r_y,
    output logic [7:0]         addr_r_x,
    output logic [3:0]         addr_r_y,
    output logic               data_valid,
    output logic               win_last,
    output logic               busy,
    output logic               done,
    output logic               cfg_err
);

    import sa_ctrl_pkg::*;

    localparam int RW  = ADDR_DW + 1;
    localparam int CW1 = CH_DW + 1;

    fsm_state_t state;
    cfg_t       cfg_in;
    cfg_t       cfg_q;

    logic start_ok;
    logic issue;

    logic [5:0]    span;
    logic [RW-1:0] pos_lim;
    logic [RW-1:0] ry_step;
    logic [RW-1:0] bx_step;
    logic [4:0]    k_lim;
    logic [CW1-1:0] c_lim;

    logic [3:0]         kx;
    logic [3:0]         ky;
    logic [CH_DW-1:0]   ch;
    logic [ADDR_DW-1:0] bx;
    logic [ADDR_DW-1:0] ry;

    logic wrap_kx;
    logic wrap_ky;
    logic wrap_ch;
    logic wrap_bx;
    logic wrap_ry;

    assign cfg_in = '{
        stride:      cfg_stride,
        kernel_dim:  cfg_kernel_dim,
        infmap_rows: cfg_infmap_rows,
        num_ch:      CH_DW_MAX'(cfg_num_ch)
    };

    assign start_ok = start && (state == IDLE) && cfg_legal(cfg_in);
    assign issue    = (state == RUN) && ready;
    assign RAenable = issue;

    // Limits come from the latched cfg so a changing cfg bus mid-pass is harmless.
    assign span    = cfg_q.infmap_rows - {2'b00, cfg_q.kernel_dim};
    assign pos_lim = RW'(span);
    assign ry_step = RW'(cfg_q.stride);
    assign bx_step = RW'(cfg_q.stride) * RW'(ROWS);
    assign k_lim   = {1'b0, cfg_q.kernel_dim - 4'd1};
    assign c_lim   = CW1'(cfg_q.num_ch - 1'b1);

    wrap_cnt #(.W(4)) u_kx (
        .clk(clk), .rst(rst), .clear(start_ok), .inc(issue),
        .step(5'd1), .limit(k_lim), .count(kx), .wrap(wrap_kx)
    );

    wrap_cnt #(.W(4)) u_ky (
        .clk(clk), .rst(rst), .clear(start_ok), .inc(wrap_kx),
        .step(5'd1), .limit(k_lim), .count(ky), .wrap(wrap_ky)
    );

    wrap_cnt #(.W(CH_DW)) u_ch (
        .clk(clk), .rst(rst), .clear(start_ok), .inc(wrap_ky),
        .step(CW1'(1)), .limit(c_lim), .count(ch), .wrap(wrap_ch)
    );

    wrap_cnt #(.W(ADDR_DW)) u_bx (
        .clk(clk), .rst(rst), .clear(start_ok), .inc(wrap_ch),
        .step(bx_step), .limit(pos_lim), .count(bx), .wrap(wrap_bx)
    );

    wrap_cnt #(.W(ADDR_DW)) u_ry (
        .clk(clk), .rst(rst), .clear(start_ok), .inc(wrap_bx),
        .step(ry_step), .limit(pos_lim), .count(ry), .wrap(wrap_ry)
    );

    assign ch_select_r    = ch;
    assign ram_select_r_x = bx;
    assign ram_select_r_y = ry;
    assign addr_r_x       = {4'b0000, kx};
    assign addr_r_y       = ky;

    // data_valid/win_last trail the issue by one cycle to match the RAM read
    // latency; done is raised on the final issue so it lands with the last data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cfg_q      <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            cfg_err    <= 1'b0;
            data_valid <= 1'b0;
            win_last   <= 1'b0;
        end else begin
            done       <= 1'b0;
            cfg_err    <= 1'b0;
            data_valid <= issue;
            win_last   <= wrap_ch;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (cfg_legal(cfg_in)) begin
                            cfg_q <= cfg_in;
                            busy  <= 1'b1;
                            state <= RUN;
                        end else begin
                            cfg_err <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (wrap_ry) begin
                        done  <= 1'b1;
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
